// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared types and constants for the add_arb block.
// Holds the 65-bit operand bundle layout, the output-buffer state enum
// and the byte-sum helper used by the top level.
package add_arb_pkg;

   // Width of one requester's operand bundle on req_data.
   localparam int DATA_W = 65;

   // Default width of the registered result.
   localparam int SUM_W_DEF = 10;

   // Widest possible untruncated sum: 8 * 255 + 1 = 2041 needs 11 bits.
   localparam int SUM_FULL_W = 11;

   // Four bytes, x at the LSB end.
   typedef struct packed {
      logic [7:0] w;
      logic [7:0] z;
      logic [7:0] y;
      logic [7:0] x;
   } vec4_t;

   // Operand bundle: s1 in [31:0], cin in [32], s2 in [64:33].
   typedef struct packed {
      vec4_t s2;
      logic  cin;
      vec4_t s1;
   } bundle_t;

   // One-entry output buffer occupancy.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Full-precision sum of all eight bytes plus the carry-in.
   function automatic logic [SUM_FULL_W-1:0] bundle_sum(input bundle_t b);
      return SUM_FULL_W'(b.s1.x) + SUM_FULL_W'(b.s1.y) +
             SUM_FULL_W'(b.s1.z) + SUM_FULL_W'(b.s1.w) +
             SUM_FULL_W'(b.s2.x) + SUM_FULL_W'(b.s2.y) +
             SUM_FULL_W'(b.s2.z) + SUM_FULL_W'(b.s2.w) +
             SUM_FULL_W'(b.cin);
   endfunction

endpackage

// File: rtl/add_arb_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin selector.
// Searches req starting at ptr and wrapping modulo N; the first set bit wins.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] winner,
   output logic          any
);

   // One extra bit so ptr + offset never overflows before the wrap.
   logic [IW:0] idx;

   // Walk the requesters in priority order from ptr and keep the first hit.
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = {1'b0, ptr} + (IW+1)'(i);
         if (idx >= (IW+1)'(N)) begin
            idx = idx - (IW+1)'(N);
         end
         if (!any && req[idx[IW-1:0]]) begin
            any                = 1'b1;
            grant[idx[IW-1:0]] = 1'b1;
            winner             = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/add_arb.sv
// add_arb: round-robin arbiter in front of a one-entry result buffer.
// The granted requester's eight bytes plus carry-in are summed, truncated to
// SUM_W bits and registered together with the requester index.
// Handshake: a transfer happens on a requester when valid & ready are both
// high at a rising edge; ready never depends on data, and a result is
// consumed when rsp_valid & rsp_ready are high at a rising edge.
// Optional feature: define ADD_ARB_STATS_EN to add the 16-bit saturating
// stat_grants counter of accepted transfers.
module add_arb
   import add_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int SUM_W = SUM_W_DEF,
   parameter int IW    = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*65-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IW-1:0]      rsp_id,
   output logic [SUM_W-1:0]   rsp_sum,
   output logic               rsp_zero
`ifdef ADD_ARB_STATS_EN
   ,
   output logic [15:0]        stat_grants
`endif
);

   state_t          state;
   state_t          next_state;
   logic [IW-1:0]   ptr;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   winner;
   logic            any;
   logic            can_accept;
   logic            accept;
   bundle_t         sel;
   logic [SUM_FULL_W-1:0]       sum_full;
   logic [SUM_W+SUM_FULL_W-1:0] sum_ext;
   logic [SUM_W-1:0]            sum_trunc;

   rr_arbiter #(
      .N  (NREQ),
      .IW (IW)
   ) u_rr (
      .req    (req_valid),
      .ptr    (ptr),
      .grant  (grant),
      .winner (winner),
      .any    (any)
   );

   assign rsp_valid = (state == ST_FULL);

   // The buffer can take a new entry when empty or when it drains this cycle.
   // rst_n gates the grant so nothing is offered while reset is held.
   assign can_accept = (state == ST_EMPTY) | (rsp_valid & rsp_ready);
   assign req_ready  = grant & {NREQ{can_accept & rst_n}};
   assign accept     = any & can_accept & rst_n;

   // Pick the winner's bundle and form the truncated sum.
   always_comb begin
      sel       = bundle_t'(req_data[int'(winner)*DATA_W +: DATA_W]);
      sum_full  = bundle_sum(sel);
      sum_ext   = {{SUM_W{1'b0}}, sum_full};
      sum_trunc = sum_ext[SUM_W-1:0];
   end

   // Output buffer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // Buffer next state: fill on accept, empty on a drain with no refill.
   always_comb begin
      next_state = state;
      case (state)
         ST_EMPTY: if (accept) next_state = ST_FULL;
         ST_FULL:  if (rsp_ready && !accept) next_state = ST_EMPTY;
         default:  next_state = ST_EMPTY;
      endcase
   end

   // Result payload and round-robin pointer, both loaded only on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_id   <= '0;
         rsp_sum  <= '0;
         rsp_zero <= 1'b0;
         ptr      <= '0;
      end else if (accept) begin
         rsp_id   <= winner;
         rsp_sum  <= sum_trunc;
         rsp_zero <= (sum_trunc == '0);
         ptr      <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
      end
   end

`ifdef ADD_ARB_STATS_EN
   // Saturating count of accepted transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grants <= '0;
      end else if (accept && (stat_grants != 16'hFFFF)) begin
         stat_grants <= stat_grants + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_add_arb.sv
// tb_add_arb: directed bench for add_arb (NREQ=4, SUM_W=10).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_add_arb;

   logic         clk;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [259:0] req_data;
   logic [3:0]   req_ready;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [1:0]   rsp_id;
   logic [9:0]   rsp_sum;
   logic         rsp_zero;
`ifdef ADD_ARB_STATS_EN
   logic [15:0]  stat_grants;
`endif

   int n_vec;
   int n_err;

   add_arb #(
      .NREQ  (4),
      .SUM_W (10)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_zero  (rsp_zero)
`ifdef ADD_ARB_STATS_EN
      ,
      .stat_grants (stat_grants)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bundle builder: s1 bytes x,y,z,w, s2 bytes x,y,z,w, carry-in.
   function automatic logic [64:0] mk(input logic [7:0] x1, y1, z1, w1,
                                      input logic [7:0] x2, y2, z2, w2,
                                      input logic cin);
      return {w2, z2, y2, x2, cin, w1, z1, y1, x1};
   endfunction

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      req_data  = '0;
      @(posedge clk); @(posedge clk); #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
      n_vec++; if (rsp_sum !== 10'd0) begin n_err++; $display("FAIL reset_sum: got %0d want 0", rsp_sum); end
      n_vec++; if (rsp_zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", rsp_zero); end
      req_valid = '0;
      rst_n     = 1'b1;
   endtask

   task automatic test_single();
      // first edge after reset release must already accept
      req_data[64:0] = mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_id: got %0d want 0", rsp_id); end
      n_vec++; if (rsp_sum !== 10'd37) begin n_err++; $display("FAIL single_sum: got %0d want 37", rsp_sum); end
      n_vec++; if (rsp_zero !== 1'b0) begin n_err++; $display("FAIL single_zero: got %b want 0", rsp_zero); end
      req_valid = '0;
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_rdy;
      logic [7:0] b;
      do_reset();
      // requester i: all bytes i+1, cin 0 -> sum 8*(i+1)
      for (int i = 0; i < 4; i++) begin
         b = 8'(i + 1);
         req_data[i*65 +: 65] = mk(b, b, b, b, b, b, b, b, 1'b0);
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_rdy = 4'(1 << (k % 4));
         #1;
         n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy); end
         @(posedge clk); #1;
         n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", k, rsp_valid); end
         n_vec++; if (rsp_id !== 2'(k % 4)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, rsp_id, k % 4); end
         n_vec++; if (rsp_sum !== 10'(8 * (k % 4 + 1))) begin n_err++; $display("FAIL rr_sum[%0d]: got %0d want %0d", k, rsp_sum, 8 * (k % 4 + 1)); end
      end
      req_valid = '0;
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_overflow();
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      req_data[64:0] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
      @(posedge clk); #1;
      n_vec++; if (rsp_sum !== 10'd1017) begin n_err++; $display("FAIL ovf_sum: got %0d want 1017", rsp_sum); end
      n_vec++; if (rsp_zero !== 1'b0) begin n_err++; $display("FAIL ovf_zero: got %b want 0", rsp_zero); end
      // 4*255 + 4 = 1024 -> wraps to 0
      req_data[64:0] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd4, 8'd0, 8'd0, 8'd0, 1'b0);
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b want 1", rsp_valid); end
      n_vec++; if (rsp_sum !== 10'd0) begin n_err++; $display("FAIL wrap_sum: got %0d want 0", rsp_sum); end
      n_vec++; if (rsp_zero !== 1'b1) begin n_err++; $display("FAIL wrap_zero: got %b want 1", rsp_zero); end
      req_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      req_data[64:0]   = mk(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
      @(posedge clk); #1;
      req_valid = 4'b0010;
      req_data[129:65] = mk(8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
         n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, rsp_valid); end
         n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_id[%0d]: got %0d want 0", c, rsp_id); end
         n_vec++; if (rsp_sum !== 10'd8) begin n_err++; $display("FAIL bp_sum[%0d]: got %0d want 8", c, rsp_sum); end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid: got %b want 1", rsp_valid); end
      n_vec++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_next_id: got %0d want 1", rsp_id); end
      n_vec++; if (rsp_sum !== 10'd17) begin n_err++; $display("FAIL bp_next_sum: got %0d want 17", rsp_sum); end
      req_valid = '0;
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
   endtask

   task automatic test_drop();
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      @(posedge clk); #1;
      // req2 is offered only while the buffer is blocked, then withdrawn
      req_valid = 4'b0100;
      @(posedge clk); @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL drop_empty: got %b want 0", rsp_valid); end
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL drop_no_result: got %b want 0", rsp_valid); end
   endtask

   task automatic test_reset_full();
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      req_data[194:130] = mk(8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 1'b0);
      req_data[259:195] = mk(8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 1'b0);
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_err++; $display("FAIL rf_load: got valid %b id %0d want 1/2", rsp_valid, rsp_id); end
      req_valid = '0;
      rst_n     = 1'b0;
      #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rf_async_valid: got %b want 0", rsp_valid); end
      n_vec++; if (rsp_sum !== 10'd0) begin n_err++; $display("FAIL rf_async_sum: got %0d want 0", rsp_sum); end
      @(posedge clk); #1;
      rst_n     = 1'b1;
      req_valid = 4'b1100;
      rsp_ready = 1'b1;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rf_first_grant: got %b want 0100", req_ready); end
      @(posedge clk); #1;
      n_vec++; if (rsp_id !== 2'd2 || rsp_sum !== 10'd24) begin n_err++; $display("FAIL rf_first_rsp: got id %0d sum %0d want 2/24", rsp_id, rsp_sum); end
      #1;
      n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rf_second_grant: got %b want 1000", req_ready); end
      @(posedge clk); #1;
      n_vec++; if (rsp_id !== 2'd3 || rsp_sum !== 10'd32) begin n_err++; $display("FAIL rf_second_rsp: got id %0d sum %0d want 3/32", rsp_id, rsp_sum); end
      req_valid = '0;
      @(posedge clk); #1;
   endtask

`ifdef ADD_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      n_vec++; if (stat_grants !== 16'd0) begin n_err++; $display("FAIL stats_reset: got %0d want 0", stat_grants); end
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      n_vec++; if (stat_grants !== 16'd10) begin n_err++; $display("FAIL stats_ten: got %0d want 10", stat_grants); end
      repeat (69990) @(posedge clk);
      #1;
      n_vec++; if (stat_grants !== 16'hFFFF) begin n_err++; $display("FAIL stats_sat: got %h want ffff", stat_grants); end
      do_reset();
      n_vec++; if (stat_grants !== 16'd0) begin n_err++; $display("FAIL stats_clear: got %0d want 0", stat_grants); end
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_backpressure();
      test_drop();
      test_reset_full();
`ifdef ADD_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
